// File: rtl/booth_pkg.sv
// Shared types for the Booth multiplier control path.
// Iteration FSM states and partial-product step sizes.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    DONE
  } iter_state_t;

  localparam logic [1:0] STEP_R2 = 2'd1;
  localparam logic [1:0] STEP_R4 = 2'd2;

endpackage

// File: rtl/booth_iter_counter_if.sv
// Control bundle between the Booth controller and its
// iteration counter.
interface booth_iter_counter_if #(
  parameter int WIDTH = 5
);

  logic             load;
  logic [WIDTH-1:0] len;
  logic             radix4;
  logic             en_pp;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             last;
  logic             done;

  modport master (
    output load, len, radix4, en_pp,
    input  out, busy, last, done
  );

  modport slave (
    input  load, len, radix4, en_pp,
    output out, busy, last, done
  );

endinterface

// File: rtl/booth_iter_counter.sv
// Saturating radix-2/radix-4 iteration counter with a
// three-state run sequencer for the Booth multiplier.
module booth_iter_counter
  import booth_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input logic clk,
  input logic reset,
  booth_iter_counter_if.slave bus
);

  iter_state_t      state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] len_q, len_d;
  logic [1:0]       step_q, step_d;
  logic             done_q, done_d;

  logic [WIDTH:0] sum;
  logic           hit;

  // One extra bit so the terminal compare never wraps.
  assign sum = {1'b0, out_q}
             + {{(WIDTH-1){1'b0}}, step_q};
  assign hit = sum >= {1'b0, len_q};

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    len_d   = len_q;
    step_d  = step_q;
    if (bus.load) begin
      out_d   = '0;
      len_d   = bus.len;
      step_d  = bus.radix4 ? STEP_R4 : STEP_R2;
      state_d = (bus.len == '0) ? DONE : COUNT;
    end else begin
      unique case (state_q)
        COUNT: begin
          if (bus.en_pp) begin
            if (hit) begin
              out_d   = len_q;
              state_d = DONE;
            end else begin
              out_d = sum[WIDTH-1:0];
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      out_q   <= '0;
      len_q   <= '0;
      step_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      len_q   <= len_d;
      step_q  <= step_d;
      done_q  <= done_d;
    end
  end

  assign bus.out  = out_q;
  assign bus.busy = (state_q == COUNT);
  assign bus.last = (state_q == COUNT) && hit;
  assign bus.done = done_q;

endmodule

// File: doc/booth_iter_counter.md
# booth_iter_counter

Parametrised iteration counter for the Booth multiplier control path. It replaces the plain up-counter. It latches a run length at start and advances by 1 (radix-2) or 2 (radix-4) on each partial-product enable. It saturates exactly at the run length and flags the final step, then pulses `done`. A three-state FSM sequences the run so the controller no longer decodes terminal count itself.

## Interface
- `WIDTH`, default 5: counter and length width. Maximum run length is 2^WIDTH-1.
- `clk`  input  1: sole clock. All state changes on its rising edge.
- `reset`  input  1: synchronous, active-low reset. Sampled on `clk` rising edge. Overrides all other inputs.
- `load`  input  1: start/restart a run. Latches `len` and `radix4`.
- `len`  input  WIDTH: run length in operand bits. Sampled only when `load`=1.
- `radix4`  input  1: step size select. 0 = step 1, 1 = step 2. Sampled only when `load`=1.
- `en_pp`  input  1: one partial-product step completed. Advances count when busy.
- `out`  output  WIDTH: bits processed so far in the current run.
- `busy`  output  1: FSM in COUNT.
- `last`  output  1: combinational. High in COUNT when the next accepted `en_pp` completes the run.
- `done`  output  1: single-cycle pulse, registered, in the cycle after the final step.

## Operation
- Reset (`reset`=0 at an edge):
  - `out`=0, `busy`=0, `done`=0, state IDLE.
  - Internal length and step registers are cleared to 0.
  - `last`=0 as a consequence.
- FSM states are IDLE, COUNT and DONE.
  - IDLE: `en_pp` is ignored. `load` goes to COUNT.
  - COUNT: each `en_pp` adds the step to `out`. When `out`+step ≥ length, `out` becomes length (saturating) and the state goes to DONE.
  - DONE: lasts exactly one cycle with `done`=1, then returns to IDLE. `out` holds the final value until the next `load` or reset.
- `load` from any state:
  - Sets `out` to 0.
  - Latches `len` and `radix4`.
  - If `len`=0, the state goes directly to DONE: `done` pulses next cycle and COUNT is never entered.
  - Otherwise the state goes to COUNT.
- Priority: `reset` > `load` > `en_pp`.
  - `load` and `en_pp` in the same cycle: the `en_pp` is discarded.
  - `load` during COUNT aborts the run without a `done` pulse.
  - `load` during DONE: `done` is still high that cycle, and the new run starts.
- Arithmetic:
  - The step add is computed at WIDTH+1 bits, so the compare cannot wrap.
  - `out` never exceeds the latched length.
  - `out` never wraps.
- Odd length with radix-4: the final step adds only the remainder (1).
- `last` = COUNT and (`out`+step ≥ length).

## Timing
- `load` at edge N:
  - `busy`=1 and `out`=0 after edge N.
  - With `len`=0, `done`=1 after edge N instead.
- `en_pp` accepted at edge M: `out` is updated after edge M.
- Final `en_pp` accepted at edge K:
  - After edge K: `busy`=0, `done`=1, `out`=length.
  - After edge K+1: `done`=0.
- Number of `en_pp` pulses for a run:
  - radix-2: exactly `len`.
  - radix-4: ceil(`len`/2).
- Throughput: back-to-back runs are possible by asserting `load` in the DONE cycle, giving zero idle cycles between runs.
- `last` has no register latency. It is valid in the same cycle as `out`.

## Structure
- Shared package `booth_pkg`:
  - `iter_state_t` enum (IDLE, COUNT, DONE).
  - Step constants `STEP_R2`=1 and `STEP_R4`=2.
  - The multiplier FSM imports the same enum style.
- Single module, no sub-module. The saturating step adder is inline logic.
- Registers: state, `out`, length, step, `done`.

## Test plan
- Reset mid-run: WIDTH=5, `load` with `len`=16, 5 `en_pp` pulses, then `reset`=0 for one edge. Expect `out`=0, `busy`=0, `done`=0, and `en_pp` ignored afterwards.
- Radix-2 full run: `len`=16, `radix4`=0, 16 `en_pp` pulses.
  - `last`=1 only while `out`=15.
  - After the 16th pulse: `out`=16 and a one-cycle `done`.
- Radix-4 odd length: `len`=7, `radix4`=1, `en_pp` every cycle.
  - `out` goes 0, 2, 4, 6, then 7, with `done` after the 4th pulse.
  - `last` is high while `out`=6.
- Zero length: `load` with `len`=0. Expect `done` pulse next cycle, `busy` never 1, `out`=0.
- Load priority: `load` with `len`=8, then 3 pulses, then `load`+`en_pp` together with `len`=4. Expect `out`=0 after that edge, no `done` for the aborted run, and the new run completes after 4 pulses.
- Back-to-back: assert `load` with `len`=2 in the DONE cycle. Expect `done`=1 that cycle, `busy`=1 next cycle, and `out`=0 after that edge.
